// File: rtl/i2s_sample_receiver.sv
// rtl/i2s_sample_receiver.sv - I2S receiver extracting one 16-bit sample per frame (left, right or mono mix)
module i2s_sample_receiver #(
    parameter int CHANNEL_SEL = 0,
    parameter int SLOT_BITS   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bclk,
    input  logic        lrclk,
    input  logic        sdata,
    output logic        new_sample,
    output logic [15:0] sample_out,
    output logic        frame_error
);

    if (SLOT_BITS < 17 || SLOT_BITS > 32 || CHANNEL_SEL < 0 || CHANNEL_SEL > 2) begin : g_bad_param
        $error("i2s_sample_receiver: illegal SLOT_BITS or CHANNEL_SEL");
    end

    localparam logic SEL_RIGHT = (CHANNEL_SEL == 1);
    localparam logic MONO      = (CHANNEL_SEL == 2);

    typedef enum logic [1:0] {S_SYNC, S_HUNT, S_CAPTURE, S_DONE} state_t;

    state_t      r_state;
    logic        r_bclk_meta, r_bclk_sync, r_bclk_hist;
    logic        r_lr_meta, r_lr_sync;
    logic        r_sd_meta, r_sd_sync;
    logic        r_prev_lr;
    logic        r_chan;
    logic [4:0]  r_cnt;
    logic [14:0] r_shift;
    logic [15:0] r_left;
    logic        r_left_valid;

    logic        w_bit_evt;
    logic        w_lr_change;
    logic [15:0] w_word;
    logic [15:0] w_avg;

    assign w_bit_evt   = r_bclk_sync & ~r_bclk_hist;
    assign w_lr_change = r_lr_sync != r_prev_lr;
    // The 16th bit is taken straight from the synchronizer so the word is ready on its own bit event
    assign w_word      = {r_shift, r_sd_sync};
    // floor((L+R)/2) computed as halves plus the carry of the two LSBs; equals the 17-bit sum >>> 1
    assign w_avg       = {r_left[15], r_left[15:1]} + {w_word[15], w_word[15:1]}
                       + {15'd0, r_left[0] & w_word[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_SYNC;
            r_bclk_meta  <= 1'b0;
            r_bclk_sync  <= 1'b0;
            r_bclk_hist  <= 1'b0;
            r_lr_meta    <= 1'b0;
            r_lr_sync    <= 1'b0;
            r_sd_meta    <= 1'b0;
            r_sd_sync    <= 1'b0;
            r_prev_lr    <= 1'b0;
            r_chan       <= 1'b0;
            r_cnt        <= 5'd0;
            r_shift      <= 15'd0;
            r_left       <= 16'd0;
            r_left_valid <= 1'b0;
            new_sample   <= 1'b0;
            frame_error  <= 1'b0;
            sample_out   <= 16'h0000;
        end else begin
            r_bclk_meta <= bclk;
            r_bclk_sync <= r_bclk_meta;
            r_bclk_hist <= r_bclk_sync;
            r_lr_meta   <= lrclk;
            r_lr_sync   <= r_lr_meta;
            r_sd_meta   <= sdata;
            r_sd_sync   <= r_sd_meta;
            new_sample  <= 1'b0;
            frame_error <= 1'b0;

            if (w_bit_evt) begin
                case (r_state)
                    S_SYNC: begin
                        r_prev_lr <= r_lr_sync;
                        r_state   <= S_HUNT;
                    end
                    S_HUNT, S_DONE: begin
                        if (w_lr_change) begin
                            r_prev_lr <= r_lr_sync;
                            r_chan    <= r_lr_sync;
                            r_cnt     <= 5'd0;
                            r_state   <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (w_lr_change) begin
                            frame_error  <= 1'b1;
                            r_left_valid <= 1'b0;
                            r_prev_lr    <= r_lr_sync;
                            r_chan       <= r_lr_sync;
                            r_cnt        <= 5'd0;
                        end else begin
                            r_shift <= w_word[14:0];
                            r_cnt   <= r_cnt + 5'd1;
                            if (r_cnt == 5'd15) begin
                                r_state <= S_DONE;
                                if (MONO) begin
                                    if (!r_chan) begin
                                        r_left       <= w_word;
                                        r_left_valid <= 1'b1;
                                    end else if (r_left_valid) begin
                                        sample_out   <= w_avg;
                                        new_sample   <= 1'b1;
                                        r_left_valid <= 1'b0;
                                    end
                                end else if (r_chan == SEL_RIGHT) begin
                                    sample_out <= w_word;
                                    new_sample <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= S_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_receiver.sv
// tb/tb_i2s_sample_receiver.sv - scoreboard bench driving one I2S stream into left, right and mono receivers
module tb_i2s_sample_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bclk = 1'b0;
    logic        lrclk = 1'b1;
    logic        sdata = 1'b0;
    logic [2:0]  ns;
    logic [2:0]  fe;
    logic [15:0] so [3];

    i2s_sample_receiver #(.CHANNEL_SEL(0), .SLOT_BITS(32)) u_dut0 (
        .clk(clk), .reset(reset), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .new_sample(ns[0]), .sample_out(so[0]), .frame_error(fe[0]));
    i2s_sample_receiver #(.CHANNEL_SEL(1), .SLOT_BITS(32)) u_dut1 (
        .clk(clk), .reset(reset), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .new_sample(ns[1]), .sample_out(so[1]), .frame_error(fe[1]));
    i2s_sample_receiver #(.CHANNEL_SEL(2), .SLOT_BITS(32)) u_dut2 (
        .clk(clk), .reset(reset), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .new_sample(ns[2]), .sample_out(so[2]), .frame_error(fe[2]));

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_fe;
        logic [15:0] data;
        longint      cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int failures = 0;
    int half = 8;

    // Slot-level reference state
    bit          armed = 0;
    bit          prev_cap = 0;
    int          prev_nbits = 0;
    bit          lv = 0;
    logic [15:0] lword = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input int m, input exp_t e);
        case (m)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_cmp(input int m, input bit is_fe, input logic [15:0] val);
        exp_t e;
        bit   got = 0;
        case (m)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
        endcase
        check($sformatf("dut%0d_event_expected(fe=%0d)", m, is_fe), {31'd0, got}, 32'd1);
        if (got) begin
            check($sformatf("dut%0d_event_kind", m), {31'd0, is_fe}, {31'd0, e.is_fe});
            if (!is_fe) check($sformatf("dut%0d_sample_out", m), {16'd0, val}, {16'd0, e.data});
            check($sformatf("dut%0d_event_cycle", m), 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int m = 0; m < 3; m++) begin
                if (ns[m]) pop_cmp(m, 1'b0, so[m]);
                if (fe[m]) pop_cmp(m, 1'b1, 16'h0);
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int m = 0; m < 3; m++)
            check($sformatf("%s_dut%0d_outputs", tag, m), {13'd0, ns[m], fe[m], so[m]}, 32'd0);
    endtask

    task automatic do_reset();
        bclk  = 1'b0;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_zero("in_reset");
        reset = 1'b0;
        armed = 0;
        prev_cap = 0;
        lv = 0;
        @(posedge clk);
        #1;
        check_zero("after_reset");
    endtask

    task automatic rise(input logic lr, input logic sd, output longint rc);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = sd;
        repeat (half) @(posedge clk);
        #1;
        bclk = 1'b1;
        rc   = cyc;
    endtask

    task automatic fall_wait();
        repeat (half) @(posedge clk);
        #1;
    endtask

    // Expected outputs of a completed word; strobe lands three clk cycles after the bclk rise
    task automatic complete(input logic lr, input logic [15:0] word, input longint rc);
        int sum;
        if (!lr) push(0, '{is_fe: 1'b0, data: word, cyc: rc + 3});
        else     push(1, '{is_fe: 1'b0, data: word, cyc: rc + 3});
        if (!lr) begin
            lword = word;
            lv    = 1;
        end else if (lv) begin
            sum = int'($signed(lword)) + int'($signed(word));
            push(2, '{is_fe: 1'b0, data: 16'(sum >>> 1), cyc: rc + 3});
            lv = 0;
        end
    endtask

    // One lrclk half-period of nbits bit events: delay slot, 16 data bits MSB first, then filler
    task automatic send_slot(input logic lr, input logic [15:0] word, input int nbits, input bit cont);
        bit     cap = 0;
        longint rc;
        logic   sd;
        for (int i = 0; i < nbits; i++) begin
            sd = (i >= 1 && i <= 16) ? word[16-i] : 1'($urandom);
            rise(lr, sd, rc);
            if (i == 0 && !cont) begin
                if (prev_cap && prev_nbits < 17) begin
                    for (int m = 0; m < 3; m++) push(m, '{is_fe: 1'b1, data: 16'h0, cyc: rc + 3});
                    lv = 0;
                end
                cap = armed;
            end
            if (i == 16 && cap) complete(lr, word, rc);
            fall_wait();
        end
        armed      = 1;
        prev_cap   = cap;
        prev_nbits = nbits;
    endtask

    initial begin
        int nb;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        half = 8;
        for (int f = 0; f < 3; f++) begin
            send_slot(1'b0, 16'hA5C3, 32, 0);
            send_slot(1'b1, 16'h1234, 32, 0);
        end
        send_slot(1'b0, 16'h7FFF, 32, 0);
        send_slot(1'b1, 16'h0001, 32, 0);
        send_slot(1'b0, 16'h8000, 32, 0);
        send_slot(1'b1, 16'hFFFF, 32, 0);

        send_slot(1'b0, 16'h1111, 11, 0);
        send_slot(1'b1, 16'h5678, 32, 0);
        send_slot(1'b0, 16'h2222, 32, 0);
        send_slot(1'b1, 16'h3333, 32, 0);

        send_slot(1'b0, 16'hA5C3, 9, 0);
        do_reset();
        send_slot(1'b0, 16'h0000, 23, 1);
        send_slot(1'b1, 16'h4444, 32, 0);
        send_slot(1'b0, 16'h5555, 32, 0);
        send_slot(1'b1, 16'h6666, 32, 0);

        half = 4;
        for (int f = 0; f < 150; f++) begin
            for (int c = 0; c < 2; c++) begin
                nb = ($urandom_range(0, 15) == 0) ? $urandom_range(2, 16) : $urandom_range(17, 20);
                send_slot(1'(c), 16'($urandom), nb, 0);
            end
        end
        send_slot(1'b0, 16'($urandom), 17, 0);
        send_slot(1'b1, 16'($urandom), 17, 0);

        repeat (20) @(posedge clk);
        #1;
        check("dut0_pending_expected", 32'(q0.size()), 32'd0);
        check("dut1_pending_expected", 32'(q1.size()), 32'd0);
        check("dut2_pending_expected", 32'(q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
